// File: rtl/simon_round_keysched_pkg.sv
// Shared Simon128/128 constants, block type and rotate/round helpers used by
// the datapath and the key schedule.
package simon_round_keysched_pkg;

  localparam int unsigned WORD_W = 64;
  localparam int unsigned ROUNDS = 68;
  localparam int unsigned Z_LEN  = 62;

  localparam logic [WORD_W-1:0] KS_C = 64'hFFFF_FFFF_FFFF_FFFC;

  // Ascending range so Z2_SEQ[0] is the first bit of the published z2 string.
  localparam logic [0:Z_LEN-1] Z2_SEQ =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  localparam logic [5:0] Z_LAST = 6'd61;

  typedef struct packed {
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
  } simon_block_t;

  function automatic logic [WORD_W-1:0] rol64(input logic [WORD_W-1:0] v,
                                              input int unsigned n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] ror64(input logic [WORD_W-1:0] v,
                                              input int unsigned n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] simon_f(input logic [WORD_W-1:0] v);
    return (rol64(v, 1) & rol64(v, 8)) ^ rol64(v, 2);
  endfunction

endpackage

// File: rtl/simon_round_keysched_key_schedule.sv
// Simon128/128 (m=2) on-the-fly key expansion: ka holds k[i], kb holds k[i+1].
module simon_key_schedule
  import simon_round_keysched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ks_enable_i,
  input  logic [127:0]      k0_i,
  output logic [WORD_W-1:0] kj_o
);

  logic [WORD_W-1:0] ka_q, ka_d;
  logic [WORD_W-1:0] kb_q, kb_d;
  logic [5:0]        zi_q, zi_d;
  logic [WORD_W-1:0] t;

  // z2 bit enters at the LSB only; zi walks the 62-bit sequence and wraps.
  always_comb begin
    t    = ror64(kb_q, 3);
    ka_d = ka_q;
    kb_d = kb_q;
    zi_d = zi_q;
    if (!ks_enable_i) begin
      ka_d = k0_i[63:0];
      kb_d = k0_i[127:64];
      zi_d = 6'd0;
    end else begin
      ka_d = kb_q;
      kb_d = KS_C ^ {{(WORD_W-1){1'b0}}, Z2_SEQ[zi_q]} ^ ka_q ^ t ^ ror64(t, 1);
      zi_d = (zi_q == Z_LAST) ? 6'd0 : zi_q + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ka_q <= '0;
      kb_q <= '0;
      zi_q <= '0;
    end else begin
      ka_q <= ka_d;
      kb_q <= kb_d;
      zi_q <= zi_d;
    end
  end

  assign kj_o = ka_q;

endmodule

// File: rtl/simon_round_keysched.sv
// Simon128/128 single-round-per-cycle datapath with an independent key schedule.
module simon_round_keysched
  import simon_round_keysched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic              ks_enable_i,
  input  logic              encrypt_i,
  input  logic [127:0]      pt_i,
  input  logic [127:0]      k0_i,
  input  logic [WORD_W-1:0] kj_i,
  output logic [WORD_W-1:0] kj_o,
  output logic [127:0]      ct_o
);

  simon_block_t state_q, state_d;

  // Decrypt reuses the forward round, so loading swaps the halves instead.
  always_comb begin
    state_d = state_q;
    if (enable_i) begin
      state_d.x = state_q.y ^ simon_f(state_q.x) ^ kj_i;
      state_d.y = state_q.x;
    end else if (encrypt_i) begin
      state_d = pt_i;
    end else begin
      state_d = {pt_i[63:0], pt_i[127:64]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign ct_o = state_q;

  simon_key_schedule u_key_schedule (
    .clk         (clk),
    .rst         (rst),
    .ks_enable_i (ks_enable_i),
    .k0_i        (k0_i),
    .kj_o        (kj_o)
  );

endmodule

// File: tb/tb_simon_round_keysched.sv
// Directed and randomized checks of simon_round_keysched against a word-level
// Simon128/128 reference model.
module tb_simon_round_keysched;
  import simon_round_keysched_pkg::*;

  localparam logic [127:0] KEY_REF = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] PT_REF  = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] CT_REF  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;
  localparam logic [127:0] DEC_REF = 128'h6c6c657661727420_6373656420737265;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         ksEnable;
  logic         encrypt;
  logic [127:0] pt;
  logic [127:0] key;
  logic [63:0]  kjIn;
  logic [63:0]  kjManual;
  logic [63:0]  kjOut;
  logic [127:0] ctOut;
  bit           linkKeys;

  int total = 0;
  int bad   = 0;

  logic [63:0] modelKeys [0:129];
  string zStr = "10101111011100000011010010011000101000010001111110010110110011";

  simon_round_keysched dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable),
    .ks_enable_i (ksEnable),
    .encrypt_i   (encrypt),
    .pt_i        (pt),
    .k0_i        (key),
    .kj_i        (kjIn),
    .kj_o        (kjOut),
    .ct_o        (ctOut)
  );

  always #5 clk = ~clk;

  always_comb kjIn = linkKeys ? kjOut : kjManual;

  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    int m;
    m = n % 64;
    if (m == 0) return v;
    return (v << m) | (v >> (64 - m));
  endfunction

  task automatic expandKey(input logic [127:0] k);
    modelKeys[0] = k[63:0];
    modelKeys[1] = k[127:64];
    for (int i = 0; i < 128; i++) begin
      logic [63:0] t;
      logic        zb;
      t  = rotl(modelKeys[i+1], 61);
      t  = t ^ rotl(t, 63);
      zb = (zStr[i % 62] == "1");
      modelKeys[i+2] = ~64'd3 ^ {63'd0, zb} ^ modelKeys[i] ^ t;
    end
  endtask

  // mode 0: keys k0..k67, mode 1: keys k67..k0, mode 2: fixedKey every round
  function automatic logic [127:0] modelCrypt(input logic [127:0] blk, input int mode,
                                              input logic [63:0] fixedKey);
    logic [63:0] x, y, k, nx;
    x = blk[127:64];
    y = blk[63:0];
    for (int r = 0; r < ROUNDS; r++) begin
      if (mode == 0)      k = modelKeys[r];
      else if (mode == 1) k = modelKeys[ROUNDS-1-r];
      else                k = fixedKey;
      nx = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ k;
      y  = x;
      x  = nx;
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic applyStimulus(input logic en, input logic ksEn, input logic enc,
                               input logic [127:0] p, input logic [127:0] k);
    enable   = en;
    ksEnable = ksEn;
    encrypt  = enc;
    pt       = p;
    key      = k;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  initial begin
    logic [127:0] rk, rp, prevPt, ctMid;
    logic         prevEnc;

    rst      = 1'b1;
    enable   = 1'b0;
    ksEnable = 1'b0;
    encrypt  = 1'b1;
    pt       = '0;
    key      = '0;
    kjManual = '0;
    linkKeys = 1'b1;
    #2;
    checkOutput("reset_ct", ctOut, 128'd0);
    checkOutput("reset_kj", {64'd0, kjOut}, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] key schedule run");
    expandKey(KEY_REF);
    applyStimulus(1'b0, 1'b0, 1'b1, PT_REF, KEY_REF);
    checkOutput("load_ct", ctOut, PT_REF);
    checkOutput("k0", {64'd0, kjOut}, {64'd0, 64'h0706050403020100});
    for (int s = 1; s < 130; s++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, PT_REF, KEY_REF);
      if (s == 1) checkOutput("k1", {64'd0, kjOut}, {64'd0, 64'h0f0e0d0c0b0a0908});
      else        checkOutput($sformatf("k%0d", s), {64'd0, kjOut}, {64'd0, modelKeys[s]});
    end

    $display("[TB] reference encrypt");
    applyStimulus(1'b0, 1'b0, 1'b1, PT_REF, KEY_REF);
    for (int r = 0; r < ROUNDS; r++) applyStimulus(1'b1, 1'b1, 1'b1, PT_REF, KEY_REF);
    checkOutput("enc_ref", ctOut, CT_REF);
    checkOutput("enc_model", ctOut, modelCrypt(PT_REF, 0, 64'd0));

    $display("[TB] reference decrypt");
    linkKeys = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, CT_REF, KEY_REF);
    for (int r = 0; r < ROUNDS; r++) begin
      kjManual = modelKeys[ROUNDS-1-r];
      applyStimulus(1'b1, 1'b0, 1'b0, CT_REF, KEY_REF);
    end
    checkOutput("dec_ref", ctOut, DEC_REF);
    linkKeys = 1'b1;

    $display("[TB] reset mid-run");
    applyStimulus(1'b0, 1'b0, 1'b1, PT_REF, KEY_REF);
    for (int r = 0; r < 29; r++) applyStimulus(1'b1, 1'b1, 1'b1, PT_REF, KEY_REF);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ct", ctOut, 128'd0);
    checkOutput("midrst_kj", {64'd0, kjOut}, 128'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, PT_REF, KEY_REF);
    checkOutput("rst_hold_ct", ctOut, 128'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, PT_REF, KEY_REF);
    for (int r = 0; r < ROUNDS; r++) applyStimulus(1'b1, 1'b1, 1'b1, PT_REF, KEY_REF);
    checkOutput("rerun_enc", ctOut, CT_REF);

    $display("[TB] load hold");
    prevPt  = rand128();
    prevEnc = 1'b1;
    applyStimulus(1'b0, 1'b0, prevEnc, prevPt, KEY_REF);
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("hold%0d", c), ctOut,
                  prevEnc ? prevPt : {prevPt[63:0], prevPt[127:64]});
      prevPt  = rand128();
      prevEnc = logic'($urandom_range(0, 1));
      applyStimulus(1'b0, 1'b0, prevEnc, prevPt, KEY_REF);
    end

    $display("[TB] datapath with key schedule held");
    rk = rand128();
    rp = rand128();
    applyStimulus(1'b0, 1'b0, 1'b1, rp, rk);
    for (int r = 0; r < ROUNDS; r++) applyStimulus(1'b1, 1'b0, 1'b1, rp, rk);
    checkOutput("kshold_kj", {64'd0, kjOut}, {64'd0, rk[63:0]});
    checkOutput("kshold_ct", ctOut, modelCrypt(rp, 2, rk[63:0]));

    $display("[TB] random encrypt/decrypt");
    for (int n = 0; n < 4; n++) begin
      rk = rand128();
      rp = rand128();
      expandKey(rk);
      linkKeys = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, rp, rk);
      for (int r = 0; r < ROUNDS; r++) applyStimulus(1'b1, 1'b1, 1'b1, rp, rk);
      ctMid = modelCrypt(rp, 0, 64'd0);
      checkOutput($sformatf("rnd_enc%0d", n), ctOut, ctMid);
      linkKeys = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, ctMid, rk);
      for (int r = 0; r < ROUNDS; r++) begin
        kjManual = modelKeys[ROUNDS-1-r];
        applyStimulus(1'b1, 1'b0, 1'b0, ctMid, rk);
      end
      checkOutput($sformatf("rnd_dec%0d", n), ctOut, {rp[63:0], rp[127:64]});
    end
    linkKeys = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
